// File: rtl/mem_responder.sv
// Main-memory responder: one read or write request at a time,
// byte-masked write data beat, fixed-latency single-beat read response.
module mem_responder #(
  parameter int ADDR_BITS     = 28,
  parameter int DEPTH_BITS    = 12,
  parameter int LATENCY       = 4,
  parameter int MEM_DATA_BITS = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic [ADDR_BITS-1:0]       mem_req_addr,
  input  logic                       mem_req_rw,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                       mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int MASK_BITS = MEM_DATA_BITS / 8;
  localparam int WORDS     = 1 << DEPTH_BITS;
  localparam int CNT_BITS  = $clog2(LATENCY + 1);
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    RWAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [DEPTH_BITS-1:0]   addr;
  logic [CNT_BITS-1:0]     cnt;
  logic [MEM_DATA_BITS-1:0] mem [WORDS];

  logic                    req_fire;
  logic                    wr_fire;
  logic                    rd_load;
  logic [DEPTH_BITS-1:0]   rd_idx;

  // Upper address bits alias onto the stored words and are dropped.
  logic unused_addr;
  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_BITS];

  assign req_fire = mem_req_valid && mem_req_ready;
  assign wr_fire  = mem_req_data_valid && mem_req_data_ready;

  // Latency 1 reads the array straight from the request address.
  assign rd_load = (req_fire && !mem_req_rw && LATENCY == 1)
                || (state == RWAIT && cnt == CNT_ONE);
  assign rd_idx  = (state == IDLE) ? mem_req_addr[DEPTH_BITS-1:0]
                                   : addr;

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      mem_req_ready      <= 1'b0;
      mem_req_data_ready <= 1'b0;
      mem_resp_valid     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            addr          <= mem_req_addr[DEPTH_BITS-1:0];
            mem_req_ready <= 1'b0;
            if (mem_req_rw) begin
              state              <= WDATA;
              mem_req_data_ready <= 1'b1;
            end else begin
              cnt <= CNT_INIT;
              if (LATENCY == 1) begin
                state          <= RESP;
                mem_resp_valid <= 1'b1;
              end else begin
                state <= RWAIT;
              end
            end
          end else begin
            mem_req_ready <= 1'b1;
          end
        end
        WDATA: begin
          if (mem_req_data_valid) begin
            state              <= IDLE;
            mem_req_data_ready <= 1'b0;
            mem_req_ready      <= 1'b1;
          end
        end
        RWAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state          <= RESP;
            mem_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          state          <= IDLE;
          mem_resp_valid <= 1'b0;
          mem_req_ready  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte-masked array write on the data handshake.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      for (int i = 0; i < MASK_BITS; i++) begin
        if (mem_req_data_mask[i]) begin
          mem[addr][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
        end
      end
    end
  end

  // Registered read data; holds its value between responses.
  always_ff @(posedge clk) begin
    if (!reset && rd_load) begin
      mem_resp_data <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 4 and latency 1),
// table-driven requests with a response scoreboard.
module tb_mem_responder;

  typedef struct {
    logic         rw;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    int           delay;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid [2];
  logic         req_ready [2];
  logic [27:0]  req_addr  [2];
  logic         req_rw    [2];
  logic         dvalid    [2];
  logic         dready    [2];
  logic [127:0] wdata     [2];
  logic [15:0]  wmask     [2];
  logic         resp_valid[2];
  logic [127:0] resp_data [2];

  int   cyc = 0;
  int   cmps = 0;
  int   errs = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid[0]), .mem_req_ready(req_ready[0]),
    .mem_req_addr(req_addr[0]), .mem_req_rw(req_rw[0]),
    .mem_req_data_valid(dvalid[0]), .mem_req_data_ready(dready[0]),
    .mem_req_data_bits(wdata[0]), .mem_req_data_mask(wmask[0]),
    .mem_resp_valid(resp_valid[0]), .mem_resp_data(resp_data[0])
  );

  mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid[1]), .mem_req_ready(req_ready[1]),
    .mem_req_addr(req_addr[1]), .mem_req_rw(req_rw[1]),
    .mem_req_data_valid(dvalid[1]), .mem_req_data_ready(dready[1]),
    .mem_req_data_bits(wdata[1]), .mem_req_data_mask(wmask[1]),
    .mem_resp_valid(resp_valid[1]), .mem_resp_data(resp_data[1])
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid[0]) begin
      if (q0.size() == 0) begin
        cmps++; errs++;
        $display("FAIL resp0_unexpected: got pulse at cyc %0d want none",
                 cyc);
      end else begin
        e0 = q0.pop_front();
        chk("resp0_data", resp_data[0], e0.data);
        chk("resp0_cycle", 128'(cyc), 128'(e0.cyc));
      end
    end
    if (resp_valid[1]) begin
      if (q1.size() == 0) begin
        cmps++; errs++;
        $display("FAIL resp1_unexpected: got pulse at cyc %0d want none",
                 cyc);
      end else begin
        e1 = q1.pop_front();
        chk("resp1_data", resp_data[1], e1.data);
        chk("resp1_cycle", 128'(cyc), 128'(e1.cyc));
      end
    end
  end

  // Drive a request until accepted; t is the cyc value after the
  // accepting edge, -1 on timeout.
  task automatic req(input int k, input logic rw, input logic [27:0] a,
                     output int t);
    logic r;
    req_valid[k] = 1'b1;
    req_rw[k]    = rw;
    req_addr[k]  = a;
    t = -1;
    for (int n = 0; n < 50; n++) begin
      r = req_ready[k];
      @(posedge clk); #1;
      if (r) begin
        t = cyc;
        break;
      end
    end
    req_valid[k] = 1'b0;
    if (t < 0) begin
      cmps++; errs++;
      $display("FAIL req_timeout: got no accept want accept (dut %0d)", k);
    end
  endtask

  task automatic wr(input int k, input logic [27:0] a,
                    input logic [127:0] d, input logic [15:0] m,
                    input int delay);
    int t;
    logic r;
    bit done;
    req(k, 1'b1, a, t);
    for (int i = 0; i < delay; i++) begin
      chk("wdata_hold_ready", 128'(req_ready[k]), 128'(0));
      chk("wdata_hold_dready", 128'(dready[k]), 128'(1));
      @(posedge clk); #1;
    end
    wdata[k]  = d;
    wmask[k]  = m;
    dvalid[k] = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      r = dready[k];
      @(posedge clk); #1;
      if (r) done = 1'b1;
    end
    dvalid[k] = 1'b0;
    if (!done) begin
      cmps++; errs++;
      $display("FAIL wdata_timeout: got no beat taken want taken");
    end
  endtask

  task automatic rd(input int k, input logic [27:0] a,
                    input logic [127:0] exp, output int t);
    exp_t e;
    req(k, 1'b0, a, t);
    if (t >= 0) begin
      e.data = exp;
      e.cyc  = t + ((k == 0) ? 4 : 1) - 1;
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'h00112233445566778899AABBCCDDEEAA;
  localparam logic [127:0] D3 = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;
  localparam logic [127:0] D4 = 128'h11FEF00DCAFEF00DCAFEF00DCAFEF00D;

  initial begin
    int t;
    int t1;
    int t2;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b1;
      req_addr[k]  = '0;
      req_rw[k]    = 1'b0;
      dvalid[k]    = 1'b0;
      wdata[k]     = '0;
      wmask[k]     = '0;
    end
    reset = 1'b1;

    vecs.push_back('{1'b1, 28'h5, D1, 16'hFFFF, 0});
    vecs.push_back('{1'b0, 28'h5, D1, 16'h0, 0});
    vecs.push_back('{1'b1, 28'h5, 128'h555555555555555555555555555555AA,
                     16'h0001, 0});
    vecs.push_back('{1'b0, 28'h5, D2, 16'h0, 0});
    vecs.push_back('{1'b1, 28'h5, {128{1'b1}}, 16'h0000, 0});
    vecs.push_back('{1'b0, 28'h5, D2, 16'h0, 0});
    vecs.push_back('{1'b1, 28'h1005, D3, 16'hFFFF, 5});
    vecs.push_back('{1'b0, 28'h5, D3, 16'h0, 0});
    vecs.push_back('{1'b1, 28'h5, 128'h11 << 120, 16'h8000, 0});
    vecs.push_back('{1'b0, 28'h5, D4, 16'h0, 0});
    vecs.push_back('{1'b0, 28'h1005, D4, 16'h0, 0});

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_ready0", 128'(req_ready[0]), 128'(0));
      chk("reset_ready1", 128'(req_ready[1]), 128'(0));
      chk("reset_dready0", 128'(dready[0]), 128'(0));
      chk("reset_resp0", 128'(resp_valid[0]), 128'(0));
    end
    reset = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready0", 128'(req_ready[0]), 128'(1));
    chk("post_reset_ready1", 128'(req_ready[1]), 128'(1));

    foreach (vecs[i]) begin
      if (vecs[i].rw)
        wr(0, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].delay);
      else
        rd(0, vecs[i].addr, vecs[i].data, t);
    end

    // Reset in cycle T+2 of a read must swallow the response.
    req(0, 1'b0, 28'h5, t);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midread_ready_low", 128'(req_ready[0]), 128'(0));
    @(posedge clk); #1;
    chk("midread_ready_high", 128'(req_ready[0]), 128'(1));
    repeat (8) @(posedge clk);
    #1;
    rd(0, 28'h5, D4, t);

    // Back-to-back reads on the latency-1 instance.
    wr(1, 28'h1, D1, 16'hFFFF, 0);
    wr(1, 28'h2, D3, 16'hFFFF, 0);
    rd(1, 28'h1, D1, t1);
    rd(1, 28'h2, D3, t2);
    chk("b2b_spacing", 128'(t2 - t1), 128'(2));

    repeat (10) @(posedge clk);
    #1;
    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q1_drained", 128'(q1.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
